// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill controller: FSM state encoding and
// the fill-pattern mode codes received as the first UART byte.
package mem_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV_MODE,
    ST_RECV_SEED,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

endpackage

// File: rtl/mem_fill_pattern.sv
// Combinational fill-pattern generator: word value for a given address
// under the selected mode and seed.
module mem_fill_pattern
  import mem_fill_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SAMPLE_DEPTH = 8
) (
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic [SAMPLE_DEPTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]   data
);

  logic [DATA_WIDTH-1:0] addr_ext;

  // Address is zero-extended or truncated to the word width.
  generate
    if (SAMPLE_DEPTH >= DATA_WIDTH) begin : g_trunc
      assign addr_ext = addr[DATA_WIDTH-1:0];
    end else begin : g_extend
      assign addr_ext = {{(DATA_WIDTH-SAMPLE_DEPTH){1'b0}}, addr};
    end
  endgenerate

  always_comb begin
    data = seed;
    case (mode)
      MODE_INCR: data = seed + addr_ext;
      MODE_ADDR: data = addr_ext;
      default:   data = seed;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// Memory fill controller: receives a mode byte and seed bytes over UART,
// then writes every address of the memory once with the selected pattern.
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | waiting for activate
// ST_RECV_MODE | waiting for the mode byte
// ST_RECV_SEED | collecting seed bytes, least-significant first
// ST_WRITE     | one memory write per cycle, address 0 upward
// ST_DONE      | fill complete, waiting for activate to drop
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SAMPLE_DEPTH = 8
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    activate,
  output logic                    done,
  output logic                    busy,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_we
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [SAMPLE_DEPTH-1:0] LAST_ADDR = '1;

  state_t state, state_nxt;

  logic [1:0]              mode;
  logic [DATA_WIDTH-1:0]   seed;
  logic [DATA_WIDTH-1:0]   seed_nxt;
  logic [1:0]              byte_cnt;
  logic                    last_byte;
  logic                    mode_load;
  logic                    seed_load;
  logic                    write_start;
  logic                    write_step;
  logic [SAMPLE_DEPTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]   pattern_seed;
  logic [DATA_WIDTH-1:0]   pattern_data;

  always_ff @(posedge clk_50mhz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mode_load   = 1'b0;
    seed_load   = 1'b0;
    write_start = 1'b0;
    write_step  = 1'b0;
    last_byte   = (byte_cnt == 2'(NUM_BYTES - 1));
    case (state)
      ST_IDLE: begin
        if (activate) state_nxt = ST_RECV_MODE;
      end
      ST_RECV_MODE: begin
        if (!activate) state_nxt = ST_IDLE;
        else if (rx_ready) begin
          mode_load = 1'b1;
          state_nxt = ST_RECV_SEED;
        end
      end
      ST_RECV_SEED: begin
        if (!activate) state_nxt = ST_IDLE;
        else if (rx_ready) begin
          seed_load = 1'b1;
          if (last_byte) begin
            write_start = 1'b1;
            state_nxt   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (!activate) state_nxt = ST_IDLE;
        else if (mem_addr == LAST_ADDR) state_nxt = ST_DONE;
        else write_step = 1'b1;
      end
      ST_DONE: begin
        if (!activate) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    seed_nxt = seed;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (byte_cnt == 2'(b)) seed_nxt[b*8 +: 8] = rx_data;
    end
  end

  // The first write must use the seed byte arriving this very cycle.
  assign pattern_seed = write_start ? seed_nxt : seed;
  assign addr_nxt     = write_start ? '0 : mem_addr + SAMPLE_DEPTH'(1);

  mem_fill_pattern #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SAMPLE_DEPTH(SAMPLE_DEPTH)
  ) u_pattern (
    .mode (mode),
    .seed (pattern_seed),
    .addr (addr_nxt),
    .data (pattern_data)
  );

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      mode     <= MODE_CONST;
      seed     <= '0;
      byte_cnt <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (mode_load) begin
        mode     <= rx_data[1:0];
        byte_cnt <= '0;
      end
      if (seed_load) begin
        seed     <= seed_nxt;
        byte_cnt <= byte_cnt + 2'd1;
      end
      mem_we <= write_start | write_step;
      if (write_start | write_step) begin
        mem_addr <= addr_nxt;
        mem_data <= pattern_data;
      end
    end
  end

  assign done = (state == ST_DONE);
  assign busy = (state == ST_RECV_MODE) || (state == ST_RECV_SEED) || (state == ST_WRITE);

endmodule

// File: tb/tb_mem_fill.sv
// Bench for mem_fill: an 8-bit and a 16-bit instance share clock, reset and
// UART inputs; expected writes are queued per fill and checked as they appear.
module tb_mem_fill;

  logic clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  logic        reset, activate, activate16, rx_ready;
  logic [7:0]  rx_data;
  logic        done8, busy8, we8;
  logic [7:0]  data8, addr8;
  logic        done16, busy16, we16;
  logic [15:0] data16;
  logic [7:0]  addr16;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp8_q[$];
  logic [23:0] exp16_q[$];
  logic [7:0]  mem8 [256];
  int   wr8 = 0;
  int   wr16 = 0;
  logic done_seen = 1'b0;

  mem_fill #(.DATA_WIDTH(8), .SAMPLE_DEPTH(8)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .activate(activate),
    .done(done8), .busy(busy8), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_data(data8), .mem_addr(addr8), .mem_we(we8)
  );

  mem_fill #(.DATA_WIDTH(16), .SAMPLE_DEPTH(8)) dut16 (
    .clk_50mhz(clk_50mhz), .reset(reset), .activate(activate16),
    .done(done16), .busy(busy16), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_data(data16), .mem_addr(addr16), .mem_we(we16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int mode, input int seed, input int addr, input int dw);
    int mask;
    mask = (1 << dw) - 1;
    case (mode)
      1:       return 16'((seed + addr) & mask);
      2:       return 16'(addr & mask);
      default: return 16'(seed & mask);
    endcase
  endfunction

  task automatic push_fill(input int mode, input int seed, input int dw);
    for (int a = 0; a < 256; a++) begin
      if (dw == 8) exp8_q.push_back({8'(a), model(mode, seed, a, 8)});
      else         exp16_q.push_back({8'(a), model(mode, seed, a, 16)});
    end
  endtask

  always @(negedge clk_50mhz) begin
    if (done8) done_seen = 1'b1;
    if (we8) begin
      wr8++;
      mem8[addr8] = data8;
      if (exp8_q.size() == 0) chk("wr8_unexpected", 32'(addr8), 32'hFFFF_FFFF);
      else chk("wr8", {8'h00, addr8, 8'h00, data8}, {8'h00, exp8_q.pop_front()});
    end
    if (we16) begin
      wr16++;
      if (exp16_q.size() == 0) chk("wr16_unexpected", 32'(addr16), 32'hFFFF_FFFF);
      else chk("wr16", {8'h00, addr16, data16}, {8'h00, exp16_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk_50mhz); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input int which);
    for (int i = 0; i < 600; i++) begin
      if ((which == 8) ? done8 : done16) break;
      step();
    end
    if (which == 8) chk("done8_reached", 32'(done8), 1);
    else            chk("done16_reached", 32'(done16), 1);
  endtask

  task automatic fill8(input int mode, input int seed);
    activate = 1'b1;
    step();
    chk("busy_recv", 32'(busy8), 1);
    wr8 = 0;
    push_fill(mode, seed, 8);
    send_byte(8'(mode));
    send_byte(8'(seed));
    chk("we_first", 32'(we8), 1);
    chk("addr_first", 32'(addr8), 0);
    wait_done(8);
    chk("wr8_count", wr8, 256);
    chk("we_done", 32'(we8), 0);
    chk("busy_done", 32'(busy8), 0);
    chk("addr_hold", 32'(addr8), 32'hFF);
    chk("q8_empty", exp8_q.size(), 0);
  endtask

  initial begin
    int found;
    reset = 1'b1; activate = 1'b0; activate16 = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) step();
    chk("rst_done", 32'(done8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_we", 32'(we8), 0);
    chk("rst_addr", 32'(addr8), 0);
    chk("rst_data", 32'(data8), 0);
    chk("rst_we16", 32'(we16), 0);
    reset = 1'b0;
    step();

    // Constant fill; UART traffic in DONE must not disturb seed or mode.
    fill8(0, 8'hA5);
    chk("data_hold", 32'(data8), 32'hA5);
    send_byte(8'h02);
    chk("done_ignore_seed", 32'(dut.seed), 32'hA5);
    chk("done_ignore_mode", 32'(dut.mode), 0);
    chk("done_high", 32'(done8), 1);
    activate = 1'b0;
    step();
    chk("done_drop", 32'(done8), 0);
    step();

    // Incrementing fill wraps modulo 256.
    fill8(1, 8'hF0);
    chk("incr_0f", 32'(mem8[8'h0F]), 32'hFF);
    chk("incr_10", 32'(mem8[8'h10]), 32'h00);
    activate = 1'b0;
    step();

    // Reserved mode behaves as constant.
    fill8(3, 8'h5A);
    chk("rsvd_c8", 32'(mem8[8'hC8]), 32'h5A);
    activate = 1'b0;
    step();

    // Abort by dropping activate at address 0x40.
    done_seen = 1'b0;
    activate = 1'b1;
    step();
    push_fill(0, 8'h3C, 8);
    send_byte(8'h00);
    send_byte(8'h3C);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50mhz);
      if (we8 && addr8 == 8'h40) begin found = 1; break; end
    end
    chk("abort_reach", found, 1);
    activate = 1'b0;
    step();
    chk("abort_we", 32'(we8), 0);
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_q", exp8_q.size(), 256 - 8'h41);
    exp8_q.delete();
    repeat (3) step();
    chk("abort_no_done", 32'(done_seen), 0);
    fill8(0, 8'h77);
    activate = 1'b0;
    step();

    // Reset mid-write at 0x80, with UART strobes during WRITE.
    activate = 1'b1;
    step();
    push_fill(1, 8'h10, 8);
    send_byte(8'h01);
    send_byte(8'h10);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50mhz);
      if (we8 && addr8 == 8'h80) begin found = 1; break; end
      rx_data  = 8'hFE;
      rx_ready = ((i % 5) == 2);
    end
    rx_ready = 1'b0;
    chk("reset_reach", found, 1);
    chk("write_ignore_mode", 32'(dut.mode), 1);
    chk("write_ignore_seed", 32'(dut.seed), 32'h10);
    reset = 1'b1;
    step();
    chk("mid_rst_we", 32'(we8), 0);
    chk("mid_rst_addr", 32'(addr8), 0);
    chk("mid_rst_data", 32'(data8), 0);
    chk("mid_rst_done", 32'(done8), 0);
    chk("mid_rst_busy", 32'(busy8), 0);
    chk("mid_rst_mode", 32'(dut.mode), 0);
    chk("mid_rst_seed", 32'(dut.seed), 0);
    reset = 1'b0;
    activate = 1'b0;
    chk("mid_rst_q", exp8_q.size(), 256 - 8'h81);
    exp8_q.delete();
    repeat (3) step();

    // 16-bit instance, address mode, two seed bytes LSB first.
    activate16 = 1'b1;
    step();
    wr16 = 0;
    push_fill(2, 16'h1234, 16);
    send_byte(8'h02);
    send_byte(8'h34);
    chk("w16_no_early_we", 32'(we16), 0);
    send_byte(8'h12);
    chk("w16_we_first", 32'(we16), 1);
    wait_done(16);
    chk("wr16_count", wr16, 256);
    chk("seed16", 32'(dut16.seed), 32'h1234);
    chk("q16_empty", exp16_q.size(), 0);
    activate16 = 1'b0;
    step();
    chk("done16_drop", 32'(done16), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
